// File: rtl/vga_sched_pkg.sv
// Shared types and default constants for the VGA vertical-blank update scheduler.
package vga_sched_pkg;

  typedef enum logic [1:0] {
    ST_CLOSED = 2'd0,
    ST_IDLE   = 2'd1,
    ST_SERVE  = 2'd2,
    ST_DRAIN  = 2'd3
  } sched_state_t;

  localparam int DEF_N_REQ   = 4;
  localparam int DEF_FRM_W   = 16;
  localparam int DEF_TMO_CYC = 4096;

  // Index width for a requester vector; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vga_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr, wrapping.
import vga_sched_pkg::*;

module vga_rr_pick #(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IDX_W = idx_width(DEF_N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] onehot,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    onehot   = '0;
    idx      = '0;
    valid    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cand_idx = IDX_W'(cand);
      if (!valid && req[cand_idx]) begin
        valid            = 1'b1;
        idx              = cand_idx;
        onehot[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vga_blank_scheduler.sv
// Round-robin sharing of the VGA vertical-blank window among N_REQ frame-state updaters.
// Optional grant timeout enabled by defining VGA_SCHED_TIMEOUT_EN.
import vga_sched_pkg::*;

module vga_blank_scheduler #(
  parameter int N_REQ   = DEF_N_REQ,
  parameter int FRM_W   = DEF_FRM_W,
  parameter int TMO_CYC = DEF_TMO_CYC
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_animate,
  input  logic             i_screenend,
  input  logic [N_REQ-1:0] i_req,
  input  logic [N_REQ-1:0] i_done,
  output logic [N_REQ-1:0] o_grant,
  output logic             o_window,
  output logic             o_overrun,
  output logic             o_timeout,
  output logic [FRM_W-1:0] o_frame
);

  localparam int IDX_W = idx_width(N_REQ);

  sched_state_t     state, state_nxt;
  logic             anim_prev, send_prev;
  logic             anim_edge, send_edge;
  logic [N_REQ-1:0] grant_r;
  logic [IDX_W-1:0] ptr;
  logic             overrun_r, timeout_r;
  logic [FRM_W-1:0] frame_r;

  logic [N_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;

  logic done_hit, tmo_hit;
  logic grant_start, grant_end, overrun_set, timeout_set;

  vga_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (i_req),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  assign anim_edge = i_animate & ~anim_prev;
  assign send_edge = i_screenend & ~send_prev;
  // Done strobes from requesters that do not hold the grant are masked out here.
  assign done_hit  = |(i_done & grant_r);

`ifdef VGA_SCHED_TIMEOUT_EN
  localparam int CNT_W = $clog2(TMO_CYC) + 1;
  logic [CNT_W-1:0] tmo_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tmo_cnt <= '0;
    end else if (grant_start) begin
      tmo_cnt <= '0;
    end else if (state == ST_SERVE || state == ST_DRAIN) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  assign tmo_hit = (state == ST_SERVE || state == ST_DRAIN) &&
                   (tmo_cnt == CNT_W'(TMO_CYC - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_CLOSED;
    else       state <= state_nxt;
  end

  // Screen end beats everything except an outstanding grant, which drains instead.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLOSED: if (anim_edge && !send_edge) state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (send_edge)       state_nxt = ST_CLOSED;
        else if (pick_valid) state_nxt = ST_SERVE;
      end
      ST_SERVE: begin
        if (done_hit || tmo_hit) state_nxt = send_edge ? ST_CLOSED : ST_IDLE;
        else if (send_edge)      state_nxt = ST_DRAIN;
      end
      ST_DRAIN: if (done_hit || tmo_hit) state_nxt = ST_CLOSED;
      default:  state_nxt = ST_CLOSED;
    endcase
  end

  always_comb begin
    o_window    = (state == ST_IDLE) || (state == ST_SERVE);
    grant_start = (state == ST_IDLE) && !send_edge && pick_valid;
    grant_end   = ((state == ST_SERVE) || (state == ST_DRAIN)) && (done_hit || tmo_hit);
    overrun_set = (state == ST_SERVE) && send_edge && !grant_end;
    timeout_set = ((state == ST_SERVE) || (state == ST_DRAIN)) && tmo_hit && !done_hit;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      anim_prev <= 1'b0;
      send_prev <= 1'b0;
      grant_r   <= '0;
      ptr       <= '0;
      overrun_r <= 1'b0;
      timeout_r <= 1'b0;
      frame_r   <= '0;
    end else begin
      anim_prev <= i_animate;
      send_prev <= i_screenend;
      overrun_r <= overrun_set;
      timeout_r <= timeout_set;
      if (send_edge) frame_r <= frame_r + 1'b1;
      if (grant_start) begin
        grant_r <= pick_onehot;
        ptr     <= (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
      end else if (grant_end) begin
        grant_r <= '0;
      end
    end
  end

  assign o_grant   = grant_r;
  assign o_overrun = overrun_r;
  assign o_timeout = timeout_r;
  assign o_frame   = frame_r;

endmodule
